// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: pops one byte per frame from the TX FIFO and
// serialises start, 5..8 data bits (LSB first), optional parity and 1/2 stop
// bits at a programmable bit period of (baud_div + 1) clocks.
module uart_tx_ctrl #(
  parameter int unsigned DIV_WIDTH = 16,
  parameter int unsigned WIDTH     = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_tx_en,
  input  logic [DIV_WIDTH-1:0] i_baud_div,
  input  logic [1:0]           i_data_bits,
  input  logic                 i_parity_en,
  input  logic                 i_parity_odd,
  input  logic                 i_stop2,
  input  logic                 i_fifo_empty,
  input  logic [WIDTH-1:0]     i_fifo_data,
  output logic                 o_fifo_rd_en,
  output logic                 o_tx,
  output logic                 o_busy,
  output logic                 o_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [DIV_WIDTH-1:0] r_baud_cnt;
  logic [DIV_WIDTH-1:0] r_div;
  logic [2:0]           r_bit_cnt;
  logic [WIDTH-1:0]     r_shift;
  logic [1:0]           r_data_bits;
  logic                 r_par_en;
  logic                 r_stop2;
  logic                 r_parity;
  logic                 w_bit_end;
  logic                 w_last_data;
  logic                 w_last_stop;
  logic                 w_par_calc;

  assign w_bit_end   = (r_baud_cnt == r_div);
  assign w_last_data = (r_bit_cnt == (3'd4 + {1'b0, r_data_bits}));
  assign w_last_stop = !r_stop2 || (r_bit_cnt == 3'd1);

  // Parity over the data bits actually sent; bits above the frame length are masked.
  always_comb begin
    w_par_calc = i_parity_odd;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (i < 32'd5 + 32'(i_data_bits)) w_par_calc = w_par_calc ^ i_fifo_data[i];
    end
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state and output decode.
  always_comb begin
    w_next       = r_state;
    o_tx         = 1'b1;
    o_busy       = 1'b1;
    o_done       = 1'b0;
    o_fifo_rd_en = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_busy = 1'b0;
        if (i_tx_en && !i_fifo_empty) w_next = S_FETCH;
      end
      S_FETCH: begin
        if (!i_tx_en || i_fifo_empty) w_next = S_IDLE;
        else                          w_next = S_LOAD;
      end
      S_LOAD: begin
        o_fifo_rd_en = 1'b1;
        w_next       = S_START;
      end
      S_START: begin
        o_tx = 1'b0;
        if (w_bit_end) w_next = S_DATA;
      end
      S_DATA: begin
        o_tx = r_shift[0];
        if (w_bit_end && w_last_data) w_next = r_par_en ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        o_tx = r_parity;
        if (w_bit_end) w_next = S_STOP;
      end
      S_STOP: begin
        if (w_bit_end && w_last_stop) begin
          o_done = 1'b1;
          w_next = (i_tx_en && !i_fifo_empty) ? S_FETCH : S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: config snapshot, shift register, baud and bit counters.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_baud_cnt  <= '0;
      r_div       <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_data_bits <= '0;
      r_par_en    <= 1'b0;
      r_stop2     <= 1'b0;
      r_parity    <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD: begin
          r_shift     <= i_fifo_data;
          r_div       <= i_baud_div;
          r_data_bits <= i_data_bits;
          r_par_en    <= i_parity_en;
          r_stop2     <= i_stop2;
          r_parity    <= w_par_calc;
          r_baud_cnt  <= '0;
          r_bit_cnt   <= '0;
        end
        S_START, S_PARITY: begin
          r_baud_cnt <= w_bit_end ? '0 : r_baud_cnt + 1'b1;
          r_bit_cnt  <= '0;
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_baud_cnt <= '0;
            r_shift    <= {1'b0, r_shift[WIDTH-1:1]};
            r_bit_cnt  <= w_last_data ? 3'd0 : r_bit_cnt + 3'd1;
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            r_baud_cnt <= '0;
            r_bit_cnt  <= w_last_stop ? 3'd0 : r_bit_cnt + 3'd1;
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end
        default: begin
          r_baud_cnt <= '0;
          r_bit_cnt  <= '0;
        end
      endcase
    end
  end

endmodule
